chunked_subtractor: RTL and testbench

//   Parametrised multi-cycle subtractor: diff = x - y - bin over WIDTH bits.

---
 rtl/chunked_subtractor.sv | 122 ++++++++++++
 tb/tb_chunked_subtractor.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_subtractor.sv
// ============================================================================
//  Module      : chunked_subtractor
//  Description : Multi-cycle subtractor, diff = x - y - bin, CHUNK bits per
//                cycle LSB first, with borrow-out and signed overflow flags.
//                Optional signed saturation under macro FS_SAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chunked_subtractor #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int C_NCHUNK = WIDTH / CHUNK;
    localparam int C_CW     = (C_NCHUNK > 1) ? $clog2(C_NCHUNK) : 1;

    localparam logic [1:0] C_S_IDLE = 2'd0;
    localparam logic [1:0] C_S_BUSY = 2'd1;
    localparam logic [1:0] C_S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [C_CW-1:0]  r_cnt;
    logic             r_borrow;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;

    logic [31:0]      w_lsb;
    logic [CHUNK-1:0] w_xc;
    logic [CHUNK-1:0] w_yc;
    logic [CHUNK:0]   w_sub;
    logic [WIDTH-1:0] w_diff_next;
    logic             w_last;
    logic             w_ovf;

    always_comb begin
        w_lsb       = CHUNK * 32'(r_cnt);
        w_xc        = r_x[w_lsb +: CHUNK];
        w_yc        = r_y[w_lsb +: CHUNK];
        w_sub       = {1'b0, w_xc} - {1'b0, w_yc} - {{CHUNK{1'b0}}, r_borrow};
        w_diff_next = r_diff;
        w_diff_next[w_lsb +: CHUNK] = w_sub[CHUNK-1:0];
    end

    assign w_last = (r_cnt == C_CW'(C_NCHUNK - 1));
    // Sign-based overflow test; identical to borrow-into-MSB XOR borrow-out-of-MSB.
    assign w_ovf  = (r_x[WIDTH-1] ^ r_y[WIDTH-1]) & (r_x[WIDTH-1] ^ w_diff_next[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= C_S_IDLE;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                C_S_IDLE: begin
                    if (in_valid) begin
                        r_x      <= x;
                        r_y      <= y;
                        r_borrow <= bin;
                        r_cnt    <= '0;
                        r_state  <= C_S_BUSY;
                    end
                end
                C_S_BUSY: begin
                    r_diff   <= w_diff_next;
                    r_borrow <= w_sub[CHUNK];
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_bout  <= w_sub[CHUNK];
                        r_ovf   <= w_ovf;
                        r_state <= C_S_DONE;
`ifdef FS_SAT_EN
                        if (w_ovf) begin
                            r_diff <= r_x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                   : {1'b0, {(WIDTH-1){1'b1}}};
                        end
`else
`endif
                    end
                end
                C_S_DONE: begin
                    if (out_ready) begin
                        r_state <= C_S_IDLE;
                    end
                end
                default: r_state <= C_S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == C_S_IDLE);
    assign out_valid = (r_state == C_S_DONE);
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_chunked_subtractor.sv
// ============================================================================
//  Module      : tb_chunked_subtractor
//  Description : Self-checking bench for chunked_subtractor (WIDTH=16,
//                CHUNK=4) against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_chunked_subtractor;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    int tests;
    int fails;

    chunked_subtractor #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the full operands.
    task automatic model(input logic [WIDTH-1:0] mx, input logic [WIDTH-1:0] my,
                         input logic mb, output logic [WIDTH-1:0] md,
                         output logic mbo, output logic mo);
        int ux, uy, sx, sy, ud, sd;
        ux  = int'(mx);
        uy  = int'(my);
        sx  = int'($signed(mx));
        sy  = int'($signed(my));
        ud  = ux - uy - int'(mb);
        sd  = sx - sy - int'(mb);
        mbo = (ud < 0);
        mo  = (sd > (2 ** (WIDTH - 1)) - 1) || (sd < -(2 ** (WIDTH - 1)));
        md  = WIDTH'(ud);
`ifdef FS_SAT_EN
        if (mo) md = mx[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    endtask

    // Drives one operation and reports the result and accept-to-valid latency (-1 on timeout).
    task automatic run_op(input logic [WIDTH-1:0] ax, input logic [WIDTH-1:0] ay,
                          input logic ab, output logic [WIDTH-1:0] rd,
                          output logic rbo, output logic ro, output int lat);
        int n;
        lat = -1;
        n   = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        x = ax; y = ay; bin = ab; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        x = WIDTH'($urandom); y = WIDTH'($urandom); bin = 1'($urandom);
        for (int i = 1; i <= 3 * NCHUNK + 4; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        rd = diff; rbo = bout; ro = ovf;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
        tests++;
        if (diff !== '0 || bout !== 1'b0 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: diff=%h bout=%b ovf=%b, required 0/0/0", diff, bout, ovf);
        end
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] vx [6] = '{16'h1234, 16'h0000, 16'h0005, 16'h8000, 16'h7FFF, 16'hFFFF};
        logic [WIDTH-1:0] vy [6] = '{16'h0234, 16'h0001, 16'h0005, 16'h0001, 16'hFFFF, 16'h0000};
        logic             vb [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [WIDTH-1:0] rd, ed;
        logic rbo, ro, ebo, eo;
        int lat;
        for (int i = 0; i < 6; i++) begin
            run_op(vx[i], vy[i], vb[i], rd, rbo, ro, lat);
            model(vx[i], vy[i], vb[i], ed, ebo, eo);
            tests++;
            if (lat !== NCHUNK) begin
                fails++;
                $display("FAIL directed_latency[%0d]: got %0d cycles, required %0d", i, lat, NCHUNK);
            end
            tests++;
            if (rd !== ed || rbo !== ebo || ro !== eo) begin
                fails++;
                $display("FAIL directed_result[%0d]: diff=%h bout=%b ovf=%b, required %h/%b/%b",
                         i, rd, rbo, ro, ed, ebo, eo);
            end
            release_result();
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] ax, ay, rd, ed;
        logic ab, rbo, ro, ebo, eo;
        int lat;
        for (int i = 0; i < 40; i++) begin
            ax = WIDTH'($urandom); ay = WIDTH'($urandom); ab = 1'($urandom);
            if (i % 8 == 0) ay = ax;
            run_op(ax, ay, ab, rd, rbo, ro, lat);
            model(ax, ay, ab, ed, ebo, eo);
            tests++;
            if (lat !== NCHUNK || rd !== ed || rbo !== ebo || ro !== eo) begin
                fails++;
                $display("FAIL random[%0d] x=%h y=%h bin=%b: lat=%0d diff=%h bout=%b ovf=%b, required lat=%0d %h/%b/%b",
                         i, ax, ay, ab, lat, rd, rbo, ro, NCHUNK, ed, ebo, eo);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            release_result();
        end
    endtask

    task automatic test_stall();
        logic [WIDTH-1:0] rd, ed;
        logic rbo, ro, ebo, eo;
        int lat, bad;
        run_op(16'h8000, 16'h0001, 1'b0, rd, rbo, ro, lat);
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                x = 16'h0F0F; y = 16'h0101; bin = 1'b0; in_valid = 1'b1;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (diff !== rd || bout !== rbo || ovf !== ro || in_ready !== 1'b0 || out_valid !== 1'b1)
                bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL stall_hold: %0d unstable cycles, required 0", bad);
        end
        release_result();
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL stall_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
        run_op(16'h0003, 16'h0001, 1'b0, rd, rbo, ro, lat);
        model(16'h0003, 16'h0001, 1'b0, ed, ebo, eo);
        tests++;
        if (rd !== ed || rbo !== ebo || ro !== eo) begin
            fails++;
            $display("FAIL stall_pulse_ignored: diff=%h, required %h", rd, ed);
        end
        release_result();
    endtask

    task automatic test_reset_mid_op();
        int seen;
        x = 16'h1234; y = 16'h0234; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== '0) begin
            fails++;
            $display("FAIL reset_mid_op: in_ready=%b out_valid=%b diff=%h, required 1/0/0000",
                     in_ready, out_valid, diff);
        end
        seen = 0;
        for (int c = 0; c < NCHUNK + 4; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL reset_no_result: out_valid seen %0d cycles, required 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] qd [$];
        logic [WIDTH-1:0] ed;
        logic ebo, eo;
        int acc [$];
        int c, bad;
        bad = 0;
        c = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        while (acc.size() < 4 && c < 60) begin
            if (out_valid) begin
                if (qd.size() == 0 || diff !== qd[0]) bad++;
                if (qd.size() != 0) void'(qd.pop_front());
            end
            x = WIDTH'($urandom); y = WIDTH'($urandom); bin = 1'($urandom);
            if (in_ready) begin
                acc.push_back(c);
                model(x, y, bin, ed, ebo, eo);
                qd.push_back(ed);
            end
            @(posedge clk); #1;
            c++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        tests++;
        if (acc.size() != 4 || acc[3] - acc[0] != 3 * (NCHUNK + 2)) begin
            fails++;
            $display("FAIL back_to_back_rate: %0d accepts spanning %0d cycles, required 4 spanning %0d",
                     acc.size(), (acc.size() == 4) ? acc[3] - acc[0] : -1, 3 * (NCHUNK + 2));
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL back_to_back_data: %0d wrong results, required 0", bad);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        tests = 0; fails = 0;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; y = '0; bin = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_directed();
        test_random();
        test_stall();
        test_reset_mid_op();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
